// File: rtl/spi_minion_adapter.sv
// SPI minion packet adapter: turns SPI packets into val/rdy push/pull streams, one small FIFO per direction.
// Optional sticky overrun/underrun flag on port err when SPI_MINION_ADAPTER_ERR_EN is defined.
module spi_minion_adapter #(
    parameter int pack_size = 32,
    parameter int depth     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serve,
    input  logic                 seize,
    input  logic [pack_size-1:0] to_device,
    output logic [pack_size-1:0] from_device,
    output logic [pack_size-3:0] push_msg,
    output logic                 push_val,
    input  logic                 push_rdy,
    input  logic [pack_size-3:0] pull_msg,
    input  logic                 pull_val,
    output logic                 pull_rdy,
`ifdef SPI_MINION_ADAPTER_ERR_EN
    output logic                 err,
`endif
    output logic                 dbg_state
);

    localparam int nbits = pack_size - 2;
    localparam int PW    = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW    = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    // Handshakes: a beat transfers on a rising clk edge where val && rdy; val never waits on rdy,
    // and a presented msg holds until it transfers.

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_commit;

    logic r_spc_l;
    logic r_val_l;

    logic w_wr;
    logic w_rd;
    logic w_spc;
    logic w_val;

    logic [nbits-1:0] r_push_mem [depth];
    logic [PW-1:0]    r_push_wptr;
    logic [PW-1:0]    r_push_rptr;
    logic [CW-1:0]    r_push_cnt;
    logic             w_push_enq;
    logic             w_push_deq;

    logic [nbits-1:0] r_pull_mem [depth];
    logic [PW-1:0]    r_pull_wptr;
    logic [PW-1:0]    r_pull_rptr;
    logic [CW-1:0]    r_pull_cnt;
    logic             w_pull_enq;
    logic             w_pull_deq;

    assign w_wr  = to_device[pack_size-1];
    assign w_rd  = to_device[pack_size-2];
    assign w_spc = (r_push_cnt != FULL_CNT);
    assign w_val = (r_pull_cnt != '0);

    // ---------------- transaction FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A serve in ACTIVE commits with the old latches; a coincident seize keeps us ACTIVE.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (seize) begin
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                w_commit = serve;
                if (serve && !seize) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_spc_l <= 1'b0;
            r_val_l <= 1'b0;
        end else if (seize) begin
            r_spc_l <= w_spc;
            r_val_l <= w_val;
        end
    end

    // ---------------- push FIFO (SPI -> device) ----------------
    assign w_push_enq = w_commit && w_wr && r_spc_l;
    assign w_push_deq = push_val && push_rdy;
    assign push_val   = (r_push_cnt != '0);
    assign push_msg   = r_push_mem[r_push_rptr];

    always_ff @(posedge clk) begin
        if (w_push_enq) begin
            r_push_mem[r_push_wptr] <= to_device[nbits-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_push_wptr <= '0;
            r_push_rptr <= '0;
            r_push_cnt  <= '0;
        end else begin
            if (w_push_enq) begin
                r_push_wptr <= r_push_wptr + PW'(1);
            end
            if (w_push_deq) begin
                r_push_rptr <= r_push_rptr + PW'(1);
            end
            if (w_push_enq && !w_push_deq) begin
                r_push_cnt <= r_push_cnt + CW'(1);
            end else if (!w_push_enq && w_push_deq) begin
                r_push_cnt <= r_push_cnt - CW'(1);
            end
        end
    end

    // ---------------- pull FIFO (device -> SPI) ----------------
    // pull_rdy deliberately ignores a same-cycle dequeue so it stays a pure register decode.
    assign pull_rdy   = (r_pull_cnt != FULL_CNT);
    assign w_pull_enq = pull_val && pull_rdy;
    assign w_pull_deq = w_commit && w_rd && r_val_l;

    always_ff @(posedge clk) begin
        if (w_pull_enq) begin
            r_pull_mem[r_pull_wptr] <= pull_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pull_wptr <= '0;
            r_pull_rptr <= '0;
            r_pull_cnt  <= '0;
        end else begin
            if (w_pull_enq) begin
                r_pull_wptr <= r_pull_wptr + PW'(1);
            end
            if (w_pull_deq) begin
                r_pull_rptr <= r_pull_rptr + PW'(1);
            end
            if (w_pull_enq && !w_pull_deq) begin
                r_pull_cnt <= r_pull_cnt + CW'(1);
            end else if (!w_pull_enq && w_pull_deq) begin
                r_pull_cnt <= r_pull_cnt - CW'(1);
            end
        end
    end

    assign from_device = {w_spc, w_val, (w_val ? r_pull_mem[r_pull_rptr] : {nbits{1'b0}})};

`ifdef SPI_MINION_ADAPTER_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_commit && ((w_wr && !r_spc_l) || (w_rd && !r_val_l))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule
